// File: rtl/mem_preloader.sv
// ---------------------------------------------------------------------------
// mem_preloader
//   Accepts a stream of host beats and writes each word pair into the core's
//   instruction or data memory through the core debug-write ports. The core
//   is held in reset for the whole load. After the beat flagged last, the
//   block flushes, holds core_reset for RST_CYCLES more cycles, and then
//   releases the core for good (RUN is left only by reset).
//
// Parameters
//   HOLD_CYCLES  1..15  cycles each word is presented with enable_debug high
//   RST_CYCLES   1..15  cycles core_reset stays high after the flush
//
// Build option
//   PRELOADER_ADDR_CHECK_EN  adds addr_err. It is a sticky flag, set when an
//                            accepted address does not increase for its
//                            target. A flagged load parks in FLUSH and never
//                            releases the core.
//
// Ports
//   clk, reset                     clock, asynchronous active-low reset
//   in_valid/in_ready              host beat handshake
//   in_target/in_addr/in_data1/2   beat payload (0 = inst mem, 1 = data mem)
//   in_last                        final beat of the image
//   enable_debug                   debug-write enable, high only in HOLD
//   debug_inst_addr/_data1/_data2  instruction-memory init bus
//   DebugAddress/DebugData1/2      data-memory init bus
//   core_reset                     active-high core reset, low only in RUN
//   done                           core released (RUN)
//   word_count                     beats accepted, saturates at 1023
//   addr_err                       (PRELOADER_ADDR_CHECK_EN only)
//   o_dbg_state                    current FSM state, for observation
//
// Handshake: a beat transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on the registered state,
// never on in_valid. The host may hold in_valid and its payload for as long
// as it likes; nothing is taken while in_ready is low.
// ---------------------------------------------------------------------------
module mem_preloader #(
   parameter int unsigned HOLD_CYCLES = 1,
   parameter int unsigned RST_CYCLES  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_target,
   input  logic [8:0]  in_addr,
   input  logic [31:0] in_data1,
   input  logic [31:0] in_data2,
   input  logic        in_last,
   output logic        enable_debug,
   output logic [8:0]  debug_inst_addr,
   output logic [31:0] debug_inst_data1,
   output logic [31:0] debug_inst_data2,
   output logic [8:0]  DebugAddress,
   output logic [31:0] DebugData1,
   output logic [31:0] DebugData2,
   output logic        core_reset,
   output logic        done,
   output logic [9:0]  word_count,
`ifdef PRELOADER_ADDR_CHECK_EN
   output logic        addr_err,
`endif
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HOLD     = 3'd1,
      S_FLUSH    = 3'd2,
      S_CORE_RST = 3'd3,
      S_RUN      = 3'd4
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] RST_LAST  = 4'(RST_CYCLES - 1);
   localparam logic [9:0] WC_MAX    = 10'd1023;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic        r_last;
   logic        w_accept;
   logic        w_err;

   logic [8:0]  r_inst_addr;
   logic [31:0] r_inst_data1;
   logic [31:0] r_inst_data2;
   logic [8:0]  r_data_addr;
   logic [31:0] r_data_data1;
   logic [31:0] r_data_data2;
   logic [9:0]  r_word_count;

   assign w_accept = (r_state == S_IDLE) && in_valid;

`ifdef PRELOADER_ADDR_CHECK_EN
   logic [8:0] r_prev_inst;
   logic [8:0] r_prev_data;
   logic       r_seen_inst;
   logic       r_seen_data;
   logic       r_addr_err;
   logic       w_order_bad;

   // The first beat for a target has no predecessor, so it can never be out of order.
   assign w_order_bad = in_target ? (r_seen_data && (in_addr <= r_prev_data))
                                  : (r_seen_inst && (in_addr <= r_prev_inst));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev_inst <= '0;
         r_prev_data <= '0;
         r_seen_inst <= 1'b0;
         r_seen_data <= 1'b0;
         r_addr_err  <= 1'b0;
      end else if (w_accept) begin
         if (in_target) begin
            r_prev_data <= in_addr;
            r_seen_data <= 1'b1;
         end else begin
            r_prev_inst <= in_addr;
            r_seen_inst <= 1'b1;
         end
         if (w_order_bad) r_addr_err <= 1'b1;
      end
   end

   assign addr_err = r_addr_err;
   assign w_err    = r_addr_err;
`else
   assign w_err = 1'b0;
`endif

   // State register and the shared HOLD / CORE_RST cycle counter. The counter
   // restarts on every state change, so each HOLD begins counting from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= '0;
         else if ((r_state == S_HOLD) || (r_state == S_CORE_RST))
            r_cnt <= r_cnt + 4'd1;
      end
   end

   always_comb begin
      w_next       = r_state;
      in_ready     = 1'b0;
      enable_debug = 1'b0;
      core_reset   = 1'b1;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = S_HOLD;
         end
         S_HOLD: begin
            enable_debug = 1'b1;
            if (r_cnt == HOLD_LAST) w_next = r_last ? S_FLUSH : S_IDLE;
         end
         S_FLUSH: begin
            // An address-order error parks the block here with the core held in reset.
            if (!w_err) w_next = S_CORE_RST;
         end
         S_CORE_RST: begin
            if (r_cnt == RST_LAST) w_next = S_RUN;
         end
         S_RUN: begin
            core_reset = 1'b0;
            done       = 1'b1;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Payload registers. They load only on accept, so each bus holds its value
   // through HOLD and keeps it while the other target is being written.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last       <= 1'b0;
         r_inst_addr  <= '0;
         r_inst_data1 <= '0;
         r_inst_data2 <= '0;
         r_data_addr  <= '0;
         r_data_data1 <= '0;
         r_data_data2 <= '0;
         r_word_count <= '0;
      end else if (w_accept) begin
         r_last <= in_last;
         if (in_target) begin
            r_data_addr  <= in_addr;
            r_data_data1 <= in_data1;
            r_data_data2 <= in_data2;
         end else begin
            r_inst_addr  <= in_addr;
            r_inst_data1 <= in_data1;
            r_inst_data2 <= in_data2;
         end
         if (r_word_count != WC_MAX) r_word_count <= r_word_count + 10'd1;
      end
   end

   assign debug_inst_addr  = r_inst_addr;
   assign debug_inst_data1 = r_inst_data1;
   assign debug_inst_data2 = r_inst_data2;
   assign DebugAddress     = r_data_addr;
   assign DebugData1       = r_data_data1;
   assign DebugData2       = r_data_data2;
   assign word_count       = r_word_count;
   assign o_dbg_state      = r_state;

endmodule

// File: doc/mem_preloader.md
MEM_PRELOADER -- requirements
Module: mem_preloader

Interface
REQ-001 Parameter HOLD_CYCLES, default 1: cycles each word stays on the debug ports with enable_debug high; legal range 1..15.
REQ-002 Parameter RST_CYCLES, default 2: cycles core_reset is held high after the load ends; legal range 1..15.
REQ-003 clk  input  1  single clock; all logic rises on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  host beat valid.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 in_target  input  1  0 = instruction memory, 1 = data memory.
REQ-008 in_addr  input  9  word address.
REQ-009 in_data1, in_data2  input  32 each  word pair to write.
REQ-010 in_last  input  1  final beat of the image.
REQ-011 enable_debug  output  1  core debug-write enable.
REQ-012 debug_inst_addr / debug_inst_data1 / debug_inst_data2  output  9/32/32  instruction-memory init port.
REQ-013 DebugAddress / DebugData1 / DebugData2  output  9/32/32  data-memory init port.
REQ-014 core_reset  output  1  active-high reset to the core.
REQ-015 done  output  1  core released and running.
REQ-016 word_count  output  10  beats accepted since the last reset.

Function
REQ-017 FSM states: IDLE, HOLD, FLUSH, CORE_RST, RUN.
- IDLE: in_ready=1; in_valid&in_ready registers the beat, increments word_count, goes to HOLD.
- HOLD: HOLD_CYCLES cycles, then FLUSH if the beat had in_last, else IDLE.
- FLUSH: 1 cycle, enable_debug=0, then CORE_RST.
- CORE_RST: RST_CYCLES cycles, then RUN.
- RUN: terminal until reset.
REQ-018 in_ready=1 only in IDLE, combinationally; beats offered in other states are not accepted and in_valid may stay high.
REQ-019 enable_debug=1 exactly in HOLD; port values are stable for the whole of HOLD.
REQ-020 Target 0 drives the debug_inst_* bus; the DebugAddress/DebugData* bus holds its previous value. Target 1 is the mirror case.
REQ-021 core_reset=1 in IDLE, HOLD, FLUSH and CORE_RST; 0 in RUN. done=1 only in RUN.
REQ-022 Latency from the accept edge: enable_debug rises on the next edge.
- Back-to-back beats cost HOLD_CYCLES+1 cycles each.
- After the last beat, done rises HOLD_CYCLES+1+RST_CYCLES cycles after HOLD is entered.
REQ-023 word_count saturates at 1023; further beats are still accepted and written.
REQ-024 A beat arriving in RUN is ignored: in_ready=0 and no port changes.
REQ-025 A zero-beat image is impossible; the block waits in IDLE indefinitely with core_reset=1.

Reset
REQ-026 Reset assertion at any time returns the FSM to IDLE asynchronously.
- Values on assertion: enable_debug=0, core_reset=1, done=0, word_count=0, all address/data outputs=0.
- A partially loaded image is abandoned.
REQ-027 Deassertion is taken synchronously; IDLE is entered on the first posedge clk with reset high.

Configuration
REQ-028 Macro PRELOADER_ADDR_CHECK_EN.
- Defined: output addr_err (1 bit) is added. It sets sticky when an accepted beat's in_addr is not greater than the previous accepted address for the same target. It clears only on reset.
- Defined, error present: the FSM enters FLUSH instead of CORE_RST and then holds in FLUSH with core_reset=1.
- Undefined: no addr_err port and no checking logic; address order is unconstrained.

Verification
REQ-029 Two-beat load: inst {addr 0, 0x00100393, 0x00038303}, then data {addr 0, 0x00008F00, 0x000000FF, last}.
- Each pair appears on its own port with enable_debug high for 1 cycle.
- done=1 at cycle 6 after the first accept; word_count=2.
REQ-030 HOLD_CYCLES=3, in_valid held high for 3 beats: in_ready pulses every 4 cycles and enable_debug is high 3 cycles per beat.
REQ-031 Reset asserted mid-HOLD of the 2nd beat: outputs take reset values without waiting for clk; after release, a 1-beat image loads normally.
REQ-032 1025 beats with last on the final beat: word_count=1023 and all 1025 writes occur.
REQ-033 in_valid pulsed while in RUN: no in_ready, enable_debug stays 0, done stays 1.
REQ-034 With PRELOADER_ADDR_CHECK_EN defined, inst addresses 5 then 3 (last): addr_err=1, done never rises, core_reset stays 1.
